// File: rtl/sysid_checker_master.sv
// Boot-time sanity checker: reads the system-ID and timestamp words over Avalon-MM
// and compares them with build-time constants; results stay latched until the next check.
module sysid_checker_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'h637F_6841,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] StallLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LatInit   = 2'(READ_LATENCY);

  typedef enum logic [2:0] {StIdle, StRdId, StWaitId, StRdTs, StWaitTs, StFinish} state_e;

  state_e      r_state;
  logic        r_auto;
  logic [15:0] r_stall;
  logic [1:0]  r_lat;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_auto      <= AUTO_START;
      r_stall     <= '0;
      r_lat       <= '0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start || r_auto) begin
            r_auto      <= 1'b0;
            r_state     <= StRdId;
            r_stall     <= '0;
            avm_read    <= 1'b1;
            avm_address <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
          end
        end
        StRdId, StRdTs: begin
          if (!avm_waitrequest) begin
            if (READ_LATENCY == 0) begin
              if (r_state == StRdId) begin
                id_value    <= avm_readdata;
                avm_address <= 1'b0;
                r_stall     <= '0;
                r_state     <= StRdTs;
              end else begin
                ts_value <= avm_readdata;
                avm_read <= 1'b0;
                r_state  <= StFinish;
              end
            end else begin
              avm_read <= 1'b0;
              r_lat    <= LatInit;
              r_state  <= (r_state == StRdId) ? StWaitId : StWaitTs;
            end
          end else if (r_stall == StallLast) begin
            // Abandon the whole check; the timestamp read is never issued after an ID timeout.
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            timeout     <= 1'b1;
            done        <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            busy        <= 1'b0;
            r_state     <= StIdle;
          end else begin
            r_stall <= r_stall + 16'd1;
          end
        end
        StWaitId: begin
          if (r_lat == 2'd1) begin
            id_value    <= avm_readdata;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            r_stall     <= '0;
            r_state     <= StRdTs;
          end else begin
            r_lat <= r_lat - 2'd1;
          end
        end
        StWaitTs: begin
          if (r_lat == 2'd1) begin
            ts_value <= avm_readdata;
            r_state  <= StFinish;
          end else begin
            r_lat <= r_lat - 2'd1;
          end
        end
        StFinish: begin
          id_ok       <= (id_value == EXPECTED_ID);
          ts_ok       <= (ts_value == EXPECTED_TS);
          done        <= 1'b1;
          busy        <= 1'b0;
          avm_address <= 1'b0;
          r_state     <= StIdle;
        end
        default: begin
          avm_read <= 1'b0;
          busy     <= 1'b0;
          r_state  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker_master.sv
// Scoreboarded bench: two checkers (read latency 0 and 2) each behind a small Avalon slave model.
module tb_sysid_checker_master;

  localparam logic [31:0] IdDef   = 32'h637F_6841;
  localparam logic [31:0] Garbage = 32'hDEAD_BEEF;
  localparam int unsigned ToCyc   = 8;
  localparam logic [7:0]  NoLat   = 8'hFF;

  typedef struct packed {
    logic        id_ok;
    logic        ts_ok;
    logic        to;
    logic [31:0] idv;
    logic [31:0] tsv;
    logic [7:0]  lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  exp_t        sb_q [2][$];
  logic        start_s [2];
  logic [31:0] id_w [2];
  logic [31:0] ts_w [2];
  int          stall_n [2];
  int          start_cyc [2];

  logic        read_s [2];
  logic        addr_s [2];
  logic        busy_s [2];
  logic        done_s [2];
  logic        idok_s [2];
  logic        tsok_s [2];
  logic        to_s [2];
  logic [31:0] idv_s [2];
  logic [31:0] tsv_s [2];
  int          read_hi_s [2];
  int          ts_cmd_s [2];

  task automatic chk(input int g, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL dut%0d %s: got %h, expected %h (t=%0t)", g, name, act, exp,
                              $time);
    else n_pass++;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned Lat = 2 * g;
    logic        wreq;
    logic [31:0] rdata;
    int          read_hi;
    int          ts_cmd;

    sysid_checker_master #(
      .READ_LATENCY  (Lat),
      .TIMEOUT_CYCLES(ToCyc)
    ) u_dut (
      .clock          (clk),
      .reset_n        (rst_n),
      .start          (start_s[g]),
      .avm_address    (addr_s[g]),
      .avm_read       (read_s[g]),
      .avm_readdata   (rdata),
      .avm_waitrequest(wreq),
      .busy           (busy_s[g]),
      .done           (done_s[g]),
      .id_ok          (idok_s[g]),
      .ts_ok          (tsok_s[g]),
      .timeout        (to_s[g]),
      .id_value       (idv_s[g]),
      .ts_value       (tsv_s[g])
    );

    assign read_hi_s[g] = read_hi;
    assign ts_cmd_s[g]  = ts_cmd;

    // Slave: stalls stall_n cycles per command, drives valid data only in the exact return cycle.
    initial begin : slave
      int   scnt;
      int   pend;
      logic pw, pr, pa, paddr;
      wreq = 1'b0; rdata = Garbage; read_hi = 0; ts_cmd = 0;
      scnt = 0; pend = 0; pw = 1'b0; pr = 1'b0; pa = 1'b0; paddr = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          wreq = 1'b0; rdata = Garbage; scnt = 0; pend = 0; pw = 1'b0; pr = 1'b0;
        end else begin
          if (pw && pr && read_s[g]) chk(g, "addr_stable", 32'(addr_s[g]), 32'(pa));
          rdata = Garbage;
          if (pend > 0) begin
            pend--;
            if (pend == 0) rdata = paddr ? id_w[g] : ts_w[g];
          end
          if (read_s[g]) begin
            read_hi++;
            if (!addr_s[g]) ts_cmd++;
            if (scnt < stall_n[g]) begin
              wreq = 1'b1;
              scnt++;
            end else begin
              wreq = 1'b0;
              scnt = 0;
              if (Lat == 0) rdata = addr_s[g] ? id_w[g] : ts_w[g];
              else begin
                pend  = int'(Lat);
                paddr = addr_s[g];
              end
            end
          end else begin
            wreq = 1'b0;
            scnt = 0;
          end
          pw = wreq; pr = read_s[g]; pa = addr_s[g];
        end
      end
    end

    initial begin : monitor
      logic pd;
      exp_t e;
      pd = 1'b0;
      forever begin
        @(negedge clk);
        if (done_s[g] && !pd) begin
          if (sb_q[g].size() == 0) chk(g, "unexpected_done", 32'(done_s[g]), 32'd0);
          else begin
            e = sb_q[g].pop_front();
            chk(g, "busy_at_done", 32'(busy_s[g]), 32'd0);
            chk(g, "read_at_done", 32'(read_s[g]), 32'd0);
            chk(g, "id_ok", 32'(idok_s[g]), 32'(e.id_ok));
            chk(g, "ts_ok", 32'(tsok_s[g]), 32'(e.ts_ok));
            chk(g, "timeout", 32'(to_s[g]), 32'(e.to));
            chk(g, "id_value", idv_s[g], e.idv);
            chk(g, "ts_value", tsv_s[g], e.tsv);
            if (e.lat != NoLat) chk(g, "done_latency", 32'(cyc - start_cyc[g]), 32'(e.lat));
          end
        end
        pd = done_s[g];
      end
    end
  end

  task automatic push(input int g, input logic iok, input logic tok, input logic to,
                      input logic [31:0] idv, input logic [31:0] tsv, input logic [7:0] lat);
    exp_t e;
    e = '{id_ok: iok, ts_ok: tok, to: to, idv: idv, tsv: tsv, lat: lat};
    sb_q[g].push_back(e);
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk);
    start_s[g]   = 1'b1;
    start_cyc[g] = cyc;
    @(negedge clk);
    start_s[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (done_s[g] && !busy_s[g]) hit = 1'b1;
      else @(negedge clk);
    end
    chk(g, "done_within_bound", 32'(hit), 32'd1);
  endtask

  task automatic chk_zero(input int g);
    chk(g, "rst_read", 32'(read_s[g]), 32'd0);
    chk(g, "rst_addr", 32'(addr_s[g]), 32'd0);
    chk(g, "rst_busy", 32'(busy_s[g]), 32'd0);
    chk(g, "rst_done", 32'(done_s[g]), 32'd0);
    chk(g, "rst_id_ok", 32'(idok_s[g]), 32'd0);
    chk(g, "rst_ts_ok", 32'(tsok_s[g]), 32'd0);
    chk(g, "rst_timeout", 32'(to_s[g]), 32'd0);
    chk(g, "rst_id_value", idv_s[g], 32'd0);
    chk(g, "rst_ts_value", tsv_s[g], 32'd0);
  endtask

  initial begin : stim
    int   rh, tc;
    logic hit;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; id_w[i] = IdDef; ts_w[i] = '0; stall_n[i] = 0; start_cyc[i] = 0;
    end
    push(0, 1'b1, 1'b1, 1'b0, IdDef, 32'd0, NoLat);
    push(1, 1'b1, 1'b1, 1'b0, IdDef, 32'd0, NoLat);
    repeat (3) @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    rst_n = 1'b1;
    wait_done(0);
    wait_done(1);

    // Nominal run, latency 0: done 4 cycles after start
    push(0, 1'b1, 1'b1, 1'b0, IdDef, 32'd0, 8'd4);
    pulse_start(0);
    wait_done(0);

    // Wrong ID word
    id_w[0] = 32'h1234_5678;
    push(0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'd0, 8'd4);
    pulse_start(0);
    wait_done(0);
    id_w[0] = IdDef;

    // Latency 2 with 3 stall cycles per read: 4 + 2*2 + 2*3
    stall_n[1] = 3;
    push(1, 1'b1, 1'b1, 1'b0, IdDef, 32'd0, 8'd14);
    pulse_start(1);
    wait_done(1);
    stall_n[1] = 0;

    // Wrong timestamp, latency 2, no stalls
    ts_w[1] = 32'h0000_00A5;
    push(1, 1'b1, 1'b0, 1'b0, IdDef, 32'h0000_00A5, 8'd8);
    pulse_start(1);
    wait_done(1);
    ts_w[1] = '0;

    // Stuck waitrequest: 8 stalled read cycles, then abort with no timestamp read
    stall_n[0] = 1000;
    rh = read_hi_s[0];
    tc = ts_cmd_s[0];
    push(0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 8'd9);
    pulse_start(0);
    wait_done(0);
    chk(0, "timeout_read_cycles", 32'(read_hi_s[0] - rh), ToCyc);
    chk(0, "timeout_ts_reads", 32'(ts_cmd_s[0] - tc), 32'd0);
    stall_n[0] = 0;

    // start while busy (RD_ID and FINISH cycles) is ignored
    push(0, 1'b1, 1'b1, 1'b0, IdDef, 32'd0, 8'd4);
    pulse_start(0);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk(0, "idle_after_ignored_start", 32'(busy_s[0]), 32'd0);
    end

    // New check clears the previous results on entry
    id_w[0] = 32'hABCD_0000;
    push(0, 1'b0, 1'b1, 1'b0, 32'hABCD_0000, 32'd0, 8'd4);
    pulse_start(0);
    chk(0, "clear_done", 32'(done_s[0]), 32'd0);
    chk(0, "clear_id_ok", 32'(idok_s[0]), 32'd0);
    chk(0, "clear_ts_ok", 32'(tsok_s[0]), 32'd0);
    chk(0, "clear_id_value", idv_s[0], 32'd0);
    chk(0, "rd_id_read", 32'(read_s[0]), 32'd1);
    chk(0, "rd_id_addr", 32'(addr_s[0]), 32'd1);
    wait_done(0);
    id_w[0] = IdDef;

    // Reset during WAIT_TS, then auto-start rerun
    pulse_start(1);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (busy_s[1] && !read_s[1] && !addr_s[1]) hit = 1'b1;
    end
    chk(1, "reach_wait_ts", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero(1);
    chk_zero(0);
    sb_q[0].delete();
    sb_q[1].delete();
    push(0, 1'b1, 1'b1, 1'b0, IdDef, 32'd0, NoLat);
    push(1, 1'b1, 1'b1, 1'b0, IdDef, 32'd0, NoLat);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done(0);
    wait_done(1);

    repeat (5) @(negedge clk);
    chk(0, "sb_drained", 32'(sb_q[0].size()), 32'd0);
    chk(1, "sb_drained", 32'(sb_q[1].size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
